// File: rtl/xbus_arbiter_pkg.sv
// xbus_arbiter_pkg
//   Shared constants for the two-master xbus arbiter: default bus widths,
//   default timeout, FSM state encodings, master ids and the round-robin
//   tie-break helper used by xbus_rr_pick.
package xbus_arbiter_pkg;

  localparam int XBA_ADDR_W  = 32;
  localparam int XBA_DATA_W  = 32;
  localparam int XBA_TIMEOUT = 15;
  localparam int XBA_CNT_W   = 8;

  localparam logic [1:0] XBA_IDLE   = 2'd0;
  localparam logic [1:0] XBA_ACCESS = 2'd1;
  localparam logic [1:0] XBA_RESP   = 2'd2;

  localparam logic XBA_M0 = 1'b0;
  localparam logic XBA_M1 = 1'b1;

  // Both requesting: the master that did not win last time goes next.
  function automatic logic xba_rr_winner(input logic [1:0] req, input logic last);
    if (req == 2'b11) return ~last;
    return req[1];
  endfunction

endpackage

// File: rtl/xbus_arbiter_if.sv
// xbus_arbiter_if
//   One master channel of the xbus: request/payload from the master,
//   completion pulse with read data and error back from the arbiter.
//   Ports (signals):
//     req    master -> arbiter  request, held until ack
//     addr   master -> arbiter  address
//     we     master -> arbiter  write enable
//     wdata  master -> arbiter  write data
//     ack    arbiter -> master  one-cycle completion pulse
//     rdata  arbiter -> master  read data, valid with ack
//     err    arbiter -> master  timeout error, valid with ack
//   Modports: master (the requesting side), slave (the arbiter side).
interface xbus_arbiter_if
  import xbus_arbiter_pkg::*;
#(
  parameter int ADDR_W = XBA_ADDR_W,
  parameter int DATA_W = XBA_DATA_W
) ();

  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              we;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;
  logic              err;

  modport master (output req, addr, we, wdata, input  ack, rdata, err);
  modport slave  (input  req, addr, we, wdata, output ack, rdata, err);

endinterface

// File: rtl/xbus_rr_pick.sv
// xbus_rr_pick
//   Combinational 2-way round-robin selector.
//   Ports:
//     req[1:0]  in   request vector (bit 0 = m0, bit 1 = m1)
//     last      in   master granted most recently
//     valid     out  at least one request present
//     winner    out  selected master (meaningful when valid)
module xbus_rr_pick
  import xbus_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       winner
);

  assign valid  = |req;
  assign winner = xba_rr_winner(req, last);

endmodule

// File: rtl/xbus_arbiter.sv
// xbus_arbiter
//   Two-master arbiter/sequencer in front of the data-address decoder.
//   Grants m0 (controller) or m1 (debug/host) round-robin, presents one
//   registered transaction at a time, waits for s_ack or times out, and
//   returns read data plus error to the winner with a one-cycle ack.
//   Ports:
//     clk, rst_n           clock, async active-low reset
//     m0, m1               master channels (xbus_arbiter_if.slave)
//     s_sel/s_addr/s_we/s_wdata  registered decoder request
//     s_rdata, s_ack       decoder read data and completion
//     gnt_id               owner of current/last transaction (0 = m0)
//     busy                 high whenever not idle
//
//   state  | meaning
//   IDLE   | no transaction; arbitrate incoming requests
//   ACCESS | s_sel high, payload held, waiting for s_ack or timeout
//   RESP   | one-cycle ack to the granted master
module xbus_arbiter
  import xbus_arbiter_pkg::*;
#(
  parameter int ADDR_W  = XBA_ADDR_W,
  parameter int DATA_W  = XBA_DATA_W,
  parameter int TIMEOUT = XBA_TIMEOUT,
  parameter int CNT_W   = XBA_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  xbus_arbiter_if.slave     m0,
  xbus_arbiter_if.slave     m1,
  output logic              s_sel,
  output logic [ADDR_W-1:0] s_addr,
  output logic              s_we,
  output logic [DATA_W-1:0] s_wdata,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic              s_ack,
  output logic              gnt_id,
  output logic              busy
);

  // Timeout is a down-counter loaded at grant; terminal count 0 means the
  // ACCESS state has lasted TIMEOUT cycles.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT - 1);

  logic [1:0]        state;
  logic              last;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        ack_q;
  logic [DATA_W-1:0] m0_rdata_q;
  logic [DATA_W-1:0] m1_rdata_q;
  logic              m0_err_q;
  logic              m1_err_q;
  logic              pick_valid;
  logic              pick_winner;
  logic [DATA_W-1:0] rdata_next;

  xbus_rr_pick u_pick (
    .req    ({m1.req, m0.req}),
    .last   (last),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

  // Writes return zero; a timed-out access also returns zero.
  assign rdata_next = (s_ack && !s_we) ? s_rdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= XBA_IDLE;
      last       <= XBA_M1;
      cnt        <= '0;
      s_sel      <= 1'b0;
      s_addr     <= '0;
      s_we       <= 1'b0;
      s_wdata    <= '0;
      gnt_id     <= XBA_M0;
      ack_q      <= 2'b00;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
      m0_err_q   <= 1'b0;
      m1_err_q   <= 1'b0;
    end else begin
      ack_q <= 2'b00;
      case (state)
        XBA_IDLE: begin
          if (pick_valid) begin
            s_sel   <= 1'b1;
            s_addr  <= pick_winner ? m1.addr  : m0.addr;
            s_we    <= pick_winner ? m1.we    : m0.we;
            s_wdata <= pick_winner ? m1.wdata : m0.wdata;
            gnt_id  <= pick_winner;
            last    <= pick_winner;
            cnt     <= CNT_LOAD;
            state   <= XBA_ACCESS;
          end
        end
        XBA_ACCESS: begin
          // s_ack takes priority over a coincident timeout.
          if (s_ack || (cnt == '0)) begin
            s_sel <= 1'b0;
            if (gnt_id == XBA_M1) begin
              ack_q[1]   <= 1'b1;
              m1_rdata_q <= rdata_next;
              m1_err_q   <= !s_ack;
            end else begin
              ack_q[0]   <= 1'b1;
              m0_rdata_q <= rdata_next;
              m0_err_q   <= !s_ack;
            end
            state <= XBA_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        XBA_RESP: state <= XBA_IDLE;
        default:  state <= XBA_IDLE;
      endcase
    end
  end

  assign busy     = (state != XBA_IDLE);
  assign m0.ack   = ack_q[0];
  assign m0.rdata = m0_rdata_q;
  assign m0.err   = m0_err_q;
  assign m1.ack   = ack_q[1];
  assign m1.rdata = m1_rdata_q;
  assign m1.err   = m1_err_q;

endmodule

// File: tb/tb_xbus_arbiter.sv
// tb_xbus_arbiter
//   Transaction-level reference model of the arbiter plus directed and
//   randomized master/slave stimulus; all outputs compared every cycle.
module tb_xbus_arbiter;
  import xbus_arbiter_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  xbus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m0_if ();
  xbus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m1_if ();

  logic          s_sel, s_we, gnt_id, busy;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;
  logic [DW-1:0] s_rdata = '0;
  logic          s_ack   = 1'b0;

  xbus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO), .CNT_W(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .m0      (m0_if),
    .m1      (m1_if),
    .s_sel   (s_sel),
    .s_addr  (s_addr),
    .s_we    (s_we),
    .s_wdata (s_wdata),
    .s_rdata (s_rdata),
    .s_ack   (s_ack),
    .gnt_id  (gnt_id),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // master-side drive
  logic          req_d   [2] = '{1'b0, 1'b0};
  logic          we_d    [2] = '{1'b0, 1'b0};
  logic [AW-1:0] addr_d  [2] = '{'0, '0};
  logic [DW-1:0] wdata_d [2] = '{'0, '0};
  logic [1:0]    ack_v, err_v;
  logic [DW-1:0] rd_v [2];

  assign m0_if.req = req_d[0];   assign m1_if.req = req_d[1];
  assign m0_if.addr = addr_d[0]; assign m1_if.addr = addr_d[1];
  assign m0_if.we = we_d[0];     assign m1_if.we = we_d[1];
  assign m0_if.wdata = wdata_d[0]; assign m1_if.wdata = wdata_d[1];
  assign ack_v = {m1_if.ack, m0_if.ack};
  assign err_v = {m1_if.err, m0_if.err};
  assign rd_v[0] = m0_if.rdata;
  assign rd_v[1] = m1_if.rdata;

  // ---------------- reference model (transaction level) ----------------
  bit            mdl_acc = 0, mdl_resp = 0;
  int            mdl_owner = 0, mdl_last = 1, mdl_age = 0;
  logic [AW-1:0] mdl_addr = '0;
  logic          mdl_we = 1'b0;
  logic [DW-1:0] mdl_wdata = '0;
  logic [DW-1:0] mdl_rd [2] = '{'0, '0};
  logic          mdl_err [2] = '{1'b0, 1'b0};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdl_acc = 0; mdl_resp = 0; mdl_owner = 0; mdl_last = 1; mdl_age = 0;
      mdl_addr = '0; mdl_we = 1'b0; mdl_wdata = '0;
      mdl_rd[0] = '0; mdl_rd[1] = '0; mdl_err[0] = 1'b0; mdl_err[1] = 1'b0;
    end else if (mdl_resp) begin
      mdl_resp = 0;
    end else if (mdl_acc) begin
      mdl_age = mdl_age + 1;
      if (s_ack || mdl_age == TO) begin
        mdl_rd[mdl_owner]  = (s_ack && !mdl_we) ? s_rdata : '0;
        mdl_err[mdl_owner] = !s_ack;
        mdl_acc  = 0;
        mdl_resp = 1;
      end
    end else if (req_d[0] || req_d[1]) begin
      if (req_d[0] && req_d[1]) mdl_owner = 1 - mdl_last;
      else                      mdl_owner = req_d[1] ? 1 : 0;
      mdl_last  = mdl_owner;
      mdl_addr  = addr_d[mdl_owner];
      mdl_we    = we_d[mdl_owner];
      mdl_wdata = wdata_d[mdl_owner];
      mdl_age   = 0;
      mdl_acc   = 1;
    end
  end

  // ---------------- checking ----------------
  int n_vec = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("s_sel", s_sel, mdl_acc);
    chk("busy", busy, mdl_acc || mdl_resp);
    chk("gnt_id", gnt_id, mdl_owner[0]);
    chk("s_addr", s_addr, mdl_addr);
    chk("s_we", s_we, mdl_we);
    chk("s_wdata", s_wdata, mdl_wdata);
    for (int x = 0; x < 2; x++) begin
      chk($sformatf("m%0d_ack", x), ack_v[x], mdl_resp && (mdl_owner == x));
      chk($sformatf("m%0d_rdata", x), rd_v[x], mdl_rd[x]);
      chk($sformatf("m%0d_err", x), err_v[x], mdl_err[x]);
    end
  endtask

  // ---------------- stimulus agents ----------------
  bit            pend [2] = '{0, 0};
  int            raise_pct = 0, keep_pct = 0, drop_pct = 0;
  int            lat_force = -1;
  int            sel_cnt = 0, cur_lat = 0;
  bit            noise = 0, rdata_fix_en = 0;
  logic [DW-1:0] rdata_fix = '0;

  function automatic bit roll(input int pct);
    return $urandom_range(0, 99) < pct;
  endfunction

  task automatic new_payload(input int x);
    addr_d[x]  = $urandom();
    we_d[x]    = 1'($urandom_range(0, 1));
    wdata_d[x] = $urandom();
  endtask

  task automatic issue(input int x, input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d);
    addr_d[x] = a; we_d[x] = w; wdata_d[x] = d; req_d[x] = 1'b1; pend[x] = 1;
  endtask

  // One cycle: compare at the falling edge, then update master/slave drive.
  task automatic tick();
    @(negedge clk);
    compare_all();
    for (int x = 0; x < 2; x++) begin
      if (ack_v[x]) begin
        pend[x] = 0;
        if (roll(keep_pct)) begin new_payload(x); req_d[x] = 1'b1; pend[x] = 1; end
        else req_d[x] = 1'b0;
      end else if (pend[x] && req_d[x] && s_sel && gnt_id == 1'(x) && roll(drop_pct)) begin
        req_d[x] = 1'b0;
      end else if (!pend[x] && roll(raise_pct)) begin
        new_payload(x); req_d[x] = 1'b1; pend[x] = 1;
      end
    end
    if (s_sel) begin
      sel_cnt++;
      if (sel_cnt == 1) cur_lat = (lat_force >= 0) ? lat_force : int'($urandom_range(0, 5));
      s_ack = (cur_lat != 0) && (sel_cnt == cur_lat);
    end else begin
      sel_cnt = 0;
      s_ack = noise && ($urandom_range(0, 3) == 0);
    end
    s_rdata = rdata_fix_en ? rdata_fix : $urandom();
  endtask

  task automatic wait_ack(input int x, input int budget, output int sel_cycles);
    bit got = 0;
    sel_cycles = 0;
    for (int i = 0; i < budget && !got; i++) begin
      tick();
      if (s_sel) sel_cycles++;
      if (ack_v[x]) got = 1;
    end
    if (!got) chk($sformatf("ack_wait_m%0d", x), 0, 1);
  endtask

  task automatic drain(input int budget);
    bit done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      tick();
      if (!pend[0] && !pend[1] && !busy && !req_d[0] && !req_d[1]) done = 1;
    end
    if (!done) chk("drain_idle", 0, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_d[0] = 1'b0; req_d[1] = 1'b0; pend[0] = 0; pend[1] = 0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int sc;
    int ng;
    int acks;
    logic gseq [6];
    bit prev_sel;

    // reset state
    tick();
    chk("rst_s_sel", s_sel, 0); chk("rst_busy", busy, 0); chk("rst_gnt", gnt_id, 0);
    chk("rst_ack", ack_v, 0);   chk("rst_s_addr", s_addr, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // single write, slave acks in first select cycle
    lat_force = 1;
    issue(0, 32'h1004, 1'b1, 32'hDEADBEEF);
    tick();
    chk("wr_s_sel", s_sel, 1); chk("wr_s_addr", s_addr, 32'h1004);
    chk("wr_s_we", s_we, 1);   chk("wr_s_wdata", s_wdata, 32'hDEADBEEF);
    tick();
    chk("wr_m0_ack", ack_v[0], 1); chk("wr_m0_err", err_v[0], 0); chk("wr_m1_ack", ack_v[1], 0);
    tick();

    // single read, ack 3 cycles after s_sel rises
    lat_force = 4; rdata_fix_en = 1; rdata_fix = 32'h12345678;
    issue(1, 32'h2000, 1'b0, 32'h0);
    wait_ack(1, 20, sc);
    chk("rd_m1_rdata", rd_v[1], 32'h12345678); chk("rd_m1_err", err_v[1], 0);
    chk("rd_gnt_id", gnt_id, 1); chk("rd_sel_cycles", sc, 4);
    rdata_fix_en = 0;
    drain(20);

    // contention from reset: strict alternation
    do_reset();
    lat_force = -1; raise_pct = 100;
    ng = 0; prev_sel = 0;
    for (int i = 0; i < 100 && ng < 6; i++) begin
      tick();
      if (s_sel && !prev_sel) begin gseq[ng] = gnt_id; ng++; end
      prev_sel = s_sel;
    end
    chk("cont_grants", ng, 6);
    for (int i = 0; i < 6; i++) chk($sformatf("cont_grant%0d", i), gseq[i], i % 2);
    raise_pct = 0;
    drain(50);

    // timeout: never acked, then acked exactly in the last cycle
    lat_force = 0;
    issue(0, 32'h3000, 1'b0, 32'h0);
    wait_ack(0, 30, sc);
    chk("to_sel_cycles", sc, TO); chk("to_m0_err", err_v[0], 1); chk("to_m0_rdata", rd_v[0], 0);
    drain(20);
    lat_force = TO; rdata_fix_en = 1; rdata_fix = 32'hA5A55A5A;
    issue(0, 32'h3004, 1'b0, 32'h0);
    wait_ack(0, 30, sc);
    chk("tob_sel_cycles", sc, TO); chk("tob_m0_err", err_v[0], 0);
    chk("tob_m0_rdata", rd_v[0], 32'hA5A55A5A);
    rdata_fix_en = 0;
    drain(20);

    // request dropped during ACCESS
    lat_force = 3;
    issue(0, 32'h4000, 1'b1, 32'h55AA55AA);
    for (int i = 0; i < 10 && !s_sel; i++) tick();
    req_d[0] = 1'b0;
    acks = 0;
    for (int i = 0; i < 10; i++) begin tick(); if (ack_v[0]) acks++; end
    chk("drop_m0_acks", acks, 1);
    drain(20);

    // async reset mid-ACCESS
    lat_force = 0;
    issue(1, 32'h5000, 1'b0, 32'h0);
    for (int i = 0; i < 10 && !s_sel; i++) tick();
    tick();
    @(posedge clk);
    #2 rst_n = 1'b0;
    req_d[0] = 1'b0; req_d[1] = 1'b0; pend[0] = 0; pend[1] = 0;
    #1;
    chk("ar_s_sel", s_sel, 0); chk("ar_busy", busy, 0); chk("ar_gnt", gnt_id, 0);
    chk("ar_s_addr", s_addr, 0); chk("ar_s_we", s_we, 0); chk("ar_s_wdata", s_wdata, 0);
    chk("ar_ack", ack_v, 0); chk("ar_err", err_v, 0);
    chk("ar_m0_rdata", rd_v[0], 0); chk("ar_m1_rdata", rd_v[1], 0);
    tick();
    rst_n = 1'b1;
    lat_force = -1;
    issue(0, 32'h6000, 1'b1, 32'h1); issue(1, 32'h6004, 1'b1, 32'h2);
    tick();
    chk("ar_first_sel", s_sel, 1); chk("ar_first_gnt", gnt_id, 0);
    drain(50);

    // randomized traffic
    noise = 1; raise_pct = 40; keep_pct = 20; drop_pct = 10;
    for (int i = 0; i < 3000; i++) tick();
    raise_pct = 0; keep_pct = 0; drop_pct = 0;
    drain(200);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
